// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - 3x3 sliding pixel window generator over a raster stream
// Two line buffers feed the right column of the window; validity comes only from the raster counters.
module window_3x3_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic [3:0] p3,
  output logic [3:0] p4,
  output logic [3:0] p5,
  output logic [3:0] p6,
  output logic [3:0] p7,
  output logic [3:0] p8,
  output logic [3:0] p9,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col, cur_col, nxt_col;
  logic [RW-1:0] row, cur_row, nxt_row;
  logic          last_col, last_row;

  logic [3:0] lb1 [IMG_W];
  logic [3:0] lb2 [IMG_W];
  logic [3:0] wt [3];
  logic [3:0] wm [3];
  logic [3:0] wb [3];

  // sof forces the current pixel to (0,0) regardless of where the counters were
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    nxt_col  = last_col ? '0 : cur_col + CW'(1);
    nxt_row  = cur_row;
    if (last_col) nxt_row = last_row ? '0 : cur_row + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        wt[i] <= '0;
        wm[i] <= '0;
        wb[i] <= '0;
      end
    end else begin
      win_valid  <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done <= pix_valid && last_row && last_col;
      if (pix_valid) begin
        col   <= nxt_col;
        row   <= nxt_row;
        wt[0] <= wt[1];
        wt[1] <= wt[2];
        wt[2] <= lb2[cur_col];
        wm[0] <= wm[1];
        wm[1] <= wm[2];
        wm[2] <= lb1[cur_col];
        wb[0] <= wb[1];
        wb[1] <= wb[2];
        wb[2] <= pix_in;
      end
    end
  end

  assign p1 = wt[0];
  assign p2 = wt[1];
  assign p3 = wt[2];
  assign p4 = wm[0];
  assign p5 = wm[1];
  assign p6 = wm[2];
  assign p7 = wb[0];
  assign p8 = wb[1];
  assign p9 = wb[2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - self-checking bench for window_3x3_gen
// Instance A is 4x4, instance B is 8x3; both are checked against a frame-array reference model.
module tb_window_3x3_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [3:0] pa_in = '0, pb_in = '0;
  logic       va = 1'b0, vb = 1'b0, sa = 1'b0, sb = 1'b0;
  logic [3:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [3:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic       wva, fda, wvb, fdb;

  window_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_in(pa_in), .pix_valid(va), .sof(sa),
    .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5), .p6(a6), .p7(a7), .p8(a8), .p9(a9),
    .win_valid(wva), .frame_done(fda)
  );

  window_3x3_gen #(.IMG_W(8), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_in(pb_in), .pix_valid(vb), .sof(sb),
    .p1(b1), .p2(b2), .p3(b3), .p4(b4), .p5(b5), .p6(b6), .p7(b7), .p8(b8), .p9(b9),
    .win_valid(wvb), .frame_done(fdb)
  );

  typedef struct {
    logic [3:0] pix;
    bit         ev;
    bit         ed;
    logic [3:0] w [9];
  } vec_t;

  vec_t tv [16];

  int checks = 0;
  int errors = 0;
  int img_w [2] = '{4, 8};
  int img_h [2] = '{4, 3};
  int mr [2] = '{0, 0};
  int mc [2] = '{0, 0};
  logic [3:0] img [2][8][8];
  int wcnt [2] = '{0, 0};
  int fdcnt [2] = '{0, 0};
  bit obs_v, obs_d;
  logic [3:0] obs_p [9];

  function automatic logic [3:0] outp(int s, int i);
    logic [3:0] a [9];
    if (s == 0) a = '{a1, a2, a3, a4, a5, a6, a7, a8, a9};
    else        a = '{b1, b2, b3, b4, b5, b6, b7, b8, b9};
    return a[i];
  endfunction

  function automatic logic outv(int s);
    return (s == 0) ? wva : wvb;
  endfunction

  function automatic logic outd(int s);
    return (s == 0) ? fda : fdb;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drives one pixel from a negedge, checks the cycle after acceptance, then idles for gap cycles.
  task automatic send(int s, logic [3:0] v, bit sf, int gap);
    bit ev, ed;
    logic [3:0] ew [9];
    bit same;
    if (s == 0) begin pa_in = v; va = 1'b1; sa = sf; end
    else        begin pb_in = v; vb = 1'b1; sb = sf; end
    @(posedge clk);
    if (sf) begin mr[s] = 0; mc[s] = 0; end
    img[s][mr[s]][mc[s]] = v;
    ev = (mr[s] >= 2) && (mc[s] >= 2);
    ed = (mr[s] == img_h[s] - 1) && (mc[s] == img_w[s] - 1);
    for (int i = 0; i < 9; i++)
      ew[i] = ev ? img[s][mr[s] - 2 + i / 3][mc[s] - 2 + i % 3] : 4'h0;
    mc[s]++;
    if (mc[s] == img_w[s]) begin
      mc[s] = 0;
      mr[s] = (mr[s] == img_h[s] - 1) ? 0 : mr[s] + 1;
    end
    @(negedge clk);
    va = 1'b0; sa = 1'b0; vb = 1'b0; sb = 1'b0;
    obs_v = outv(s);
    obs_d = outd(s);
    for (int i = 0; i < 9; i++) obs_p[i] = outp(s, i);
    check("win_valid", int'(obs_v), int'(ev));
    check("frame_done", int'(obs_d), int'(ed));
    if (ev)
      for (int i = 0; i < 9; i++) check($sformatf("model_p%0d", i + 1), int'(obs_p[i]), int'(ew[i]));
    if (obs_v) wcnt[s]++;
    if (obs_d) fdcnt[s]++;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      @(negedge clk);
      check("gap_win_valid", int'(outv(s)), 0);
      check("gap_frame_done", int'(outd(s)), 0);
      same = 1'b1;
      for (int i = 0; i < 9; i++) if (outp(s, i) !== obs_p[i]) same = 1'b0;
      check("gap_hold", int'(same), 1);
    end
  endtask

  task automatic check_zero(string name);
    for (int s = 0; s < 2; s++) begin
      check({name, "_valid"}, int'(outv(s)), 0);
      check({name, "_done"}, int'(outd(s)), 0);
      for (int i = 0; i < 9; i++) check($sformatf("%s_p%0d", name, i + 1), int'(outp(s, i)), 0);
    end
  endtask

  task automatic run_table(int gap, bit first_sof, string tag);
    for (int k = 0; k < 16; k++) begin
      send(0, tv[k].pix, first_sof && (k == 0), gap);
      check({tag, "_valid"}, int'(obs_v), int'(tv[k].ev));
      check({tag, "_done"}, int'(obs_d), int'(tv[k].ed));
      if (tv[k].ev)
        for (int i = 0; i < 9; i++) check($sformatf("%s_k%0d_p%0d", tag, k, i + 1), int'(obs_p[i]), int'(tv[k].w[i]));
    end
  endtask

  initial begin
    int first;
    for (int k = 0; k < 16; k++) begin
      tv[k].pix = 4'(k);
      tv[k].ev  = (k == 10) || (k == 11) || (k == 14) || (k == 15);
      tv[k].ed  = (k == 15);
      tv[k].w   = '{default: 4'h0};
    end
    tv[10].w = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    tv[11].w = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};
    tv[14].w = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
    tv[15].w = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};

    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back frame, then the same stream with 3-cycle gaps
    wcnt[0] = 0; fdcnt[0] = 0;
    run_table(0, 1'b1, "tbl");
    check("tbl_windows", wcnt[0], 4);
    check("tbl_frames", fdcnt[0], 1);
    wcnt[0] = 0; fdcnt[0] = 0;
    run_table(3, 1'b1, "gap");
    check("gap_windows", wcnt[0], 4);

    // two back-to-back sof frames
    wcnt[0] = 0; fdcnt[0] = 0;
    run_table(0, 1'b1, "f1");
    run_table(0, 1'b1, "f2");
    check("two_frame_windows", wcnt[0], 8);
    check("two_frame_done", fdcnt[0], 2);

    // asynchronous reset mid-frame after k=7, restart without sof
    for (int k = 0; k < 8; k++) send(0, 4'(k), k == 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mr = '{0, 0};
    mc = '{0, 0};
    wcnt[0] = 0; fdcnt[0] = 0;
    run_table(0, 1'b0, "post_rst");
    check("post_rst_windows", wcnt[0], 4);

    // sof injected at k=9 abandons the partial frame
    wcnt[0] = 0; fdcnt[0] = 0;
    for (int k = 0; k < 9; k++) send(0, 4'(k), k == 0, 0);
    check("abort_no_window", wcnt[0], 0);
    first = -1;
    for (int i = 0; i < 16; i++) begin
      send(0, 4'((9 + i) % 16), i == 0, 0);
      if (obs_v && first < 0) first = i;
    end
    check("abort_first_window_idx", first, 10);
    check("abort_windows", wcnt[0], 4);
    check("abort_frame_done", fdcnt[0], 1);

    // random frames with random gaps on both geometries
    for (int f = 0; f < 2; f++) begin
      wcnt[0] = 0; fdcnt[0] = 0;
      for (int k = 0; k < 16; k++) send(0, 4'($urandom), k == 0, int'($urandom_range(0, 2)));
      check("rand_a_windows", wcnt[0], 4);
      check("rand_a_done", fdcnt[0], 1);
      wcnt[1] = 0; fdcnt[1] = 0;
      for (int k = 0; k < 24; k++) send(1, 4'($urandom), k == 0, int'($urandom_range(0, 2)));
      check("rand_b_windows", wcnt[1], 6);
      check("rand_b_done", fdcnt[1], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
